// File: rtl/vga_tile_capture_pkg.sv
// Shared types and geometry for the VGA tile capture block.
// The 640x480 frame is split into 32x32 tiles, which gives a 20x15 grid.
// Four tiles are packed into each 32-bit word, so a frame is 75 words.
package vga_cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_V,
    CAPTURE,
    DONE
  } cap_state_t;

  localparam int H_ACTIVE      = 640;
  localparam int V_ACTIVE      = 480;
  localparam int TILE_LOG2     = 5;
  localparam int TILES_X       = 20;
  localparam int TILES_Y       = 15;
  localparam int WORDS_PER_ROW = 5;
  localparam int NUM_WORDS     = 75;

  // Each captured byte keeps the top two bits of every colour channel.
  function automatic logic [7:0] pack_pixel(input logic [1:0] r, input logic [1:0] g,
                                            input logic [1:0] b);
    return {2'b00, r, g, b};
  endfunction

endpackage

// File: rtl/vga_tile_capture_if.sv
// Signals between the tile capture block and its environment.
// The video input comes from the on-chip generator. The write port drives the video RAM.
// master = environment (drives video, receives RAM writes); slave = capture block.
interface vga_tile_capture_if;
  logic [3:0] VGA_R;
  logic [3:0] VGA_G;
  logic [3:0] VGA_B;
  logic       VGA_HS_I;
  logic       VGA_VS_I;
  logic [6:0] waddr;
  logic [31:0] wdata;
  logic       we;
  logic       frame_done;
  logic       locked;

  modport master (
    output VGA_R, VGA_G, VGA_B, VGA_HS_I, VGA_VS_I,
    input  waddr, wdata, we, frame_done, locked
  );

  modport slave (
    input  VGA_R, VGA_G, VGA_B, VGA_HS_I, VGA_VS_I,
    output waddr, wdata, we, frame_done, locked
  );
endinterface

// File: rtl/vga_tile_capture_sync_fall_detect.sv
// Falling-edge detector for an active-low sync line.
// The pulse fires combinationally on the first low cycle.
// The stored previous value resets high, so an idle sync line produces no false edge.
module sync_fall_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_n,
  output logic fall
);

  logic prev;

  // Remember last cycle's sync level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= 1'b1;
    else          prev <= sync_n;
  end

  assign fall = prev & ~sync_n;

endmodule

// File: rtl/vga_tile_capture.sv
// VGA tile capture: recovers the raster position from the sync edges.
// It samples the centre pixel of every 32x32 tile and packs four tiles per word.
// The words are written in ascending order into a word-addressed video RAM.
import vga_cap_pkg::*;

module vga_tile_capture #(
  parameter int H_START   = 144,
  parameter int V_START   = 35,
  parameter int H_TIMEOUT = 1023
) (
  input logic              clk,
  input logic              reset_n,
  input logic              cap_en,
  vga_tile_capture_if.slave vga
);

  localparam logic [9:0] H_START_C   = 10'(H_START);
  localparam logic [9:0] V_START_C   = 10'(V_START);
  localparam logic [9:0] H_END_C     = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_END_C     = 10'(V_START + V_ACTIVE);
  localparam logic [9:0] H_TIMEOUT_C = 10'(H_TIMEOUT);
  localparam int         TILE_MID    = 1 << (TILE_LOG2 - 1);
  localparam logic [6:0] LAST_ADDR   = 7'(NUM_WORDS - 1);
  localparam logic [6:0] WPR         = 7'(WORDS_PER_ROW);

  logic       hs_fall, vs_fall;
  logic [9:0] hcnt, vcnt, hpos, vpos, x, y;
  logic [4:0] tile_col, tile_row;
  logic       in_active, sample, timeout;
  logic [7:0] pixel;
  logic [6:0] word_addr;
  logic [31:0] shift_q;
  cap_state_t state;
  logic [6:0] waddr_q;
  logic [31:0] wdata_q;
  logic       we_q, frame_done_q, locked_q;
  logic       unused_lsbs;

  sync_fall_detect u_hs_fall (.clk(clk), .reset_n(reset_n), .sync_n(vga.VGA_HS_I), .fall(hs_fall));
  sync_fall_detect u_vs_fall (.clk(clk), .reset_n(reset_n), .sync_n(vga.VGA_VS_I), .fall(vs_fall));

  // Only the top two bits of each colour channel are captured.
  assign unused_lsbs = ^{vga.VGA_R[1:0], vga.VGA_G[1:0], vga.VGA_B[1:0]};

  // Position of the current cycle. The first low sync cycle is position 0.
  // When VS and HS fall together, VS wins and that line is not counted.
  always_comb begin
    hpos = (hcnt == H_TIMEOUT_C) ? hcnt : hcnt + 10'd1;
    if (hs_fall) hpos = 10'd0;
    vpos = vcnt;
    if (vs_fall)                       vpos = 10'd0;
    else if (hs_fall && vcnt != 10'h3FF) vpos = vcnt + 10'd1;
    x         = hpos - H_START_C;
    y         = vpos - V_START_C;
    tile_col  = x[9:TILE_LOG2];
    tile_row  = y[9:TILE_LOG2];
    in_active = (hpos >= H_START_C) && (hpos < H_END_C) && (vpos >= V_START_C) && (vpos < V_END_C);
    sample    = (state == CAPTURE) && in_active
                && (x[TILE_LOG2-1:0] == TILE_MID[TILE_LOG2-1:0])
                && (y[TILE_LOG2-1:0] == TILE_MID[TILE_LOG2-1:0]);
    timeout   = (hpos == H_TIMEOUT_C) && (hcnt != H_TIMEOUT_C);
    pixel     = pack_pixel(vga.VGA_R[3:2], vga.VGA_G[3:2], vga.VGA_B[3:2]);
    word_addr = {2'b00, tile_row} * WPR + {4'b0000, tile_col[4:2]};
  end

  // Register the raster position for the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= hpos;
      vcnt <= vpos;
    end
  end

  // Capture FSM, packer and RAM write port.
  // A VS fall always re-arms or idles the capture and discards any partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shift_q      <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      if (vs_fall) begin
        locked_q <= 1'b1;
        shift_q  <= '0;
        state    <= cap_en ? WAIT_V : IDLE;
      end else if (timeout) begin
        locked_q <= 1'b0;
        shift_q  <= '0;
        state    <= IDLE;
      end else begin
        case (state)
          WAIT_V: begin
            if (hs_fall && vpos == V_START_C) state <= CAPTURE;
          end
          CAPTURE: begin
            if (we_q && waddr_q == LAST_ADDR) begin
              frame_done_q <= 1'b1;
              state        <= DONE;
            end else if (sample) begin
              case (tile_col[1:0])
                2'd0: shift_q[31:24] <= pixel;
                2'd1: shift_q[23:16] <= pixel;
                2'd2: shift_q[15:8]  <= pixel;
                default: begin
                  we_q    <= 1'b1;
                  waddr_q <= word_addr;
                  wdata_q <= {shift_q[31:8], pixel};
                  shift_q <= '0;
                end
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign vga.waddr      = waddr_q;
  assign vga.wdata      = wdata_q;
  assign vga.we         = we_q;
  assign vga.frame_done = frame_done_q;
  assign vga.locked     = locked_q;

endmodule

// File: tb/tb_vga_tile_capture.sv
// Directed bench for vga_tile_capture.
// Non-sampled lines are shortened to 4 clocks so that full frames stay cheap.
module tb_vga_tile_capture;

  logic clk;
  logic reset_n;
  logic cap_en;

  vga_tile_capture_if vif ();

  vga_tile_capture dut (
    .clk    (clk),
    .reset_n(reset_n),
    .cap_en (cap_en),
    .vga    (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_total = 0;
  int fd_total = 0;
  int order_err = 0;
  int overlap_err = 0;
  int last_addr = -1;
  logic [31:0] mem [0:127];

  // Shadow RAM plus write/frame_done bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (vif.we === 1'b1) begin
      we_total++;
      if (vif.waddr != 7'd0 && int'(vif.waddr) != last_addr + 1) order_err++;
      last_addr = int'(vif.waddr);
      mem[vif.waddr] = vif.wdata;
    end
    if (vif.frame_done === 1'b1) fd_total++;
    if (vif.we === 1'b1 && vif.frame_done === 1'b1) overlap_err++;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Colour at active position (x,y).
  // Mode 1: tile (0,0) is 4'hC, all other tiles are 0.
  // Mode 2: only the tile centres carry index k; all other pixels are white.
  function automatic logic [11:0] pixel_rgb(input int mode, input int x, input int y);
    int col, row, k;
    if (x < 0 || x >= 640 || y < 0 || y >= 480) return 12'h000;
    col = x / 32;
    row = y / 32;
    if (mode == 1) return (col == 0 && row == 0) ? 12'hCCC : 12'h000;
    if (mode == 2) begin
      if (x % 32 != 16 || y % 32 != 16) return 12'hFFF;
      k = (row * 5 + col / 4) & 63;
      return {2'(k >> 4), 2'b00, 2'(k >> 2), 2'b00, 2'(k), 2'b00};
    end
    return 12'h000;
  endfunction

  function automatic logic [31:0] exp_word(input int k);
    logic [7:0] b;
    b = 8'(k & 63);
    return {b, b, b, b};
  endfunction

  // One line. Line 0 starts with VS and HS falling together, and VS stays low for 2 lines.
  task automatic drive_line(input int l, input int mode);
    int y, len;
    logic [11:0] rgb;
    y   = l - 35;
    len = (y >= 0 && y < 480 && (y % 32) == 16) ? 790 : 4;
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      vif.VGA_HS_I = (c == 0) ? 1'b0 : 1'b1;
      vif.VGA_VS_I = (l < 2) ? 1'b0 : 1'b1;
      rgb = pixel_rgb(mode, c - 144, y);
      vif.VGA_R = rgb[11:8];
      vif.VGA_G = rgb[7:4];
      vif.VGA_B = rgb[3:0];
    end
  endtask

  task automatic apply_stimulus(input int mode, input int first_line, input int last_line,
                                input int raise_line);
    for (int l = first_line; l <= last_line; l++) begin
      if (l == raise_line) cap_en = 1'b1;
      drive_line(l, mode);
    end
  endtask

  initial begin
    int we0, fd0, nbad;
    logic la, lb;
    reset_n = 1'b0;
    cap_en = 1'b0;
    vif.VGA_HS_I = 1'b1;
    vif.VGA_VS_I = 1'b1;
    vif.VGA_R = 4'h0;
    vif.VGA_G = 4'h0;
    vif.VGA_B = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_we", 32'(vif.we), 32'd0);
    check_output("reset_waddr", 32'(vif.waddr), 32'd0);
    check_output("reset_wdata", vif.wdata, 32'd0);
    check_output("reset_frame_done", 32'(vif.frame_done), 32'd0);
    check_output("reset_locked", 32'(vif.locked), 32'd0);
    reset_n = 1'b1;

    $display("[TB] frame A: cap_en low at VS fall, raised mid-frame");
    we0 = we_total; fd0 = fd_total;
    apply_stimulus(1, 0, 519, 100);
    check_output("a_we_count", 32'(we_total - we0), 32'd0);
    check_output("a_frame_done", 32'(fd_total - fd0), 32'd0);
    check_output("a_locked", 32'(vif.locked), 32'd1);

    $display("[TB] frame B: single coloured tile");
    we0 = we_total; fd0 = fd_total;
    apply_stimulus(1, 0, 519, -1);
    check_output("b_word0", mem[0], 32'h3F00_0000);
    nbad = 0;
    for (int k = 1; k < 75; k++) if (mem[k] !== 32'd0) nbad++;
    check_output("b_words_nonzero", 32'(nbad), 32'd0);
    check_output("b_we_count", 32'(we_total - we0), 32'd75);
    check_output("b_frame_done", 32'(fd_total - fd0), 32'd1);

    $display("[TB] frame C: aborted at line 200");
    we0 = we_total; fd0 = fd_total;
    apply_stimulus(2, 0, 234, -1);
    check_output("c_we_count", 32'(we_total - we0), 32'd30);
    check_output("c_frame_done", 32'(fd_total - fd0), 32'd0);

    $display("[TB] frame D: indexed pattern, full frame");
    we0 = we_total; fd0 = fd_total;
    apply_stimulus(2, 0, 519, -1);
    nbad = 0;
    for (int k = 0; k < 75; k++) if (mem[k] !== exp_word(k)) nbad++;
    check_output("d_bad_words", 32'(nbad), 32'd0);
    check_output("d_word74", mem[74], 32'h0A0A_0A0A);
    check_output("d_word5", mem[5], 32'h0505_0505);
    check_output("d_we_count", 32'(we_total - we0), 32'd75);
    check_output("d_frame_done", 32'(fd_total - fd0), 32'd1);

    $display("[TB] HS stopped for 1100 clocks");
    la = 1'b0;
    lb = 1'b1;
    for (int c = 0; c < 1100; c++) begin
      @(posedge clk);
      #1;
      vif.VGA_HS_I = (c == 0) ? 1'b0 : 1'b1;
      vif.VGA_VS_I = 1'b1;
      @(negedge clk);
      if (c == 1023) la = vif.locked;
      if (c == 1024) lb = vif.locked;
    end
    check_output("hs_locked_at_1023", 32'(la), 32'd1);
    check_output("hs_locked_after_timeout", 32'(lb), 32'd0);

    $display("[TB] frame E: relock, then reset mid-capture");
    we0 = we_total;
    apply_stimulus(2, 0, 135, -1);
    check_output("e_locked", 32'(vif.locked), 32'd1);
    check_output("e_we_count", 32'(we_total - we0), 32'd15);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("rst_we", 32'(vif.we), 32'd0);
    check_output("rst_waddr", 32'(vif.waddr), 32'd0);
    check_output("rst_wdata", vif.wdata, 32'd0);
    check_output("rst_frame_done", 32'(vif.frame_done), 32'd0);
    check_output("rst_locked", 32'(vif.locked), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    we0 = we_total;
    apply_stimulus(2, 136, 519, -1);
    check_output("post_rst_we_count", 32'(we_total - we0), 32'd0);
    check_output("post_rst_locked", 32'(vif.locked), 32'd0);

    $display("[TB] frame F: capture resumes after VS fall");
    we0 = we_total;
    apply_stimulus(2, 0, 60, -1);
    check_output("f_we_count", 32'(we_total - we0), 32'd5);
    check_output("f_word4", mem[4], 32'h0404_0404);
    check_output("f_locked", 32'(vif.locked), 32'd1);

    check_output("write_order", 32'(order_err), 32'd0);
    check_output("we_frame_done_overlap", 32'(overlap_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
